// File: rtl/astro_mem_pkg.sv
// Shared types and constants for the astro ROM arbiter and its helpers.
package astro_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } loader_state_t;

    typedef enum logic {
        REG_BIOS = 1'b0,
        REG_CART = 1'b1
    } region_t;

    localparam logic [7:0] IDX_BIOS     = 8'd0;
    localparam logic [7:0] IDX_CART     = 8'd1;
    localparam int         REGION_BYTES = 8192;
    localparam int         MIN_CART     = 2048;

    // True for the two download targets that land in the ROM store.
    function automatic logic is_loader_index(input logic [7:0] idx);
        return (idx == IDX_BIOS) || (idx == IDX_CART);
    endfunction

endpackage

// File: rtl/astro_pow2_mask.sv
// Next-power-of-two address mask for a loaded cart size.
// Sizes below MIN_CART use the 2 KiB mask; the result never exceeds the 8 KiB window.
module astro_pow2_mask
    import astro_mem_pkg::*;
(
    input  logic [13:0] size,
    output logic [12:0] mask
);

    logic [13:0] clamped;
    logic [13:0] span;
    logic [13:0] smear;

    // Clamp to the minimum cart size, then take size-1 so exact powers map to themselves.
    always_comb begin
        clamped = (size < 14'(MIN_CART)) ? 14'(MIN_CART) : size;
        span    = clamped - 14'd1;
    end

    // Smear the highest set bit downwards to form an all-ones mask.
    generate
        for (genvar gi = 0; gi < 14; gi++) begin : g_smear
            assign smear[gi] = |span[13:gi];
        end
    endgenerate

    assign mask = smear[13] ? 13'h1FFF : smear[12:0];

endmodule

// File: rtl/astro_rom_arbiter.sv
// Arbiter sharing one 16 KiB x 8 ROM store between the HPS word loader,
// the BIOS read port and the cart read port.
// Optional feature macro: ASTRO_CART_MIRROR_EN (mirror short carts across the
// 8 KiB cart window; when undefined, reads past the loaded cart size return FILL_BYTE).
module astro_rom_arbiter
    import astro_mem_pkg::*;
#(
    parameter int         REGION_AW = 13,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [15:0]          ioctl_dout,
    output logic                 ioctl_wait,
    input  logic [REGION_AW-1:0] bios_addr,
    input  logic                 bios_cs_n,
    output logic [7:0]           bios_data,
    input  logic [REGION_AW-1:0] cart_addr,
    input  logic                 cart_cs_n,
    output logic [7:0]           cart_data,
    output logic [REGION_AW:0]   mem_addr,
    output logic [7:0]           mem_din,
    output logic                 mem_we,
    input  logic [7:0]           mem_dout,
    output logic [REGION_AW:0]   cart_size,
    output logic                 load_done
);

    localparam int SIZE_W = REGION_AW + 1;

    // Loader state
    loader_state_t          state_reg;
    loader_state_t          state_next;
    logic [REGION_AW-1:0]   ld_addr_reg;
    logic [15:0]            ld_data_reg;
    region_t                ld_region_reg;
    logic                   ld_in_range_reg;
    logic                   ioctl_wait_reg;
    logic                   accept;

    // Download tracking
    logic                   dl_prev_reg;
    logic                   load_done_reg;
    logic [SIZE_W-1:0]      cart_size_reg;
    logic [SIZE_W-1:0]      word_end;

    // Read path
    logic                   read_ok;
    logic                   bios_req;
    logic                   cart_sel;
    logic                   cart_req;
    logic                   cart_blk;
    logic [REGION_AW-1:0]   cart_eff;
    logic                   acc_bios_reg;
    logic                   acc_cart_reg;
    logic                   blk_cart_reg;
    logic [7:0]             bios_data_reg;
    logic [7:0]             cart_data_reg;

    // Memory port
    logic [REGION_AW:0]     hold_addr_reg;
    logic [REGION_AW:0]     mem_addr_next;
    logic [7:0]             mem_din_next;
    logic                   mem_we_next;

`ifdef ASTRO_CART_MIRROR_EN
    logic                   dl_cart_reg;
    logic [REGION_AW-1:0]   cart_mask_reg;
    logic [REGION_AW-1:0]   cart_mask_new;

    astro_pow2_mask u_pow2_mask (
        .size (cart_size_reg),
        .mask (cart_mask_new)
    );
`endif

    // A word is taken only from IDLE, during a download, for the BIOS or cart target.
    assign accept = (state_reg == IDLE) && ioctl_wr && ioctl_download
                    && is_loader_index(ioctl_index);

    // Next-state logic: each accepted word becomes a low-byte then a high-byte write.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = WR_LO;
            WR_LO:   state_next = WR_HI;
            WR_HI:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Loader registers: state, latched word and the HPS stall flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            ld_addr_reg     <= '0;
            ld_data_reg     <= '0;
            ld_region_reg   <= REG_BIOS;
            ld_in_range_reg <= 1'b0;
            ioctl_wait_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                ld_addr_reg     <= ioctl_addr[REGION_AW-1:0];
                ld_data_reg     <= ioctl_dout;
                ld_region_reg   <= (ioctl_index == IDX_CART) ? REG_CART : REG_BIOS;
                ld_in_range_reg <= (ioctl_addr[24:REGION_AW] == '0);
                ioctl_wait_reg  <= 1'b1;
            end else if (state_reg == WR_HI) begin
                ioctl_wait_reg  <= 1'b0;
            end
        end
    end

    assign word_end = {1'b0, ld_addr_reg} + SIZE_W'(2);

    // Download edge detection, load_done pulse and cart size tracking.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_prev_reg   <= 1'b0;
            load_done_reg <= 1'b0;
            cart_size_reg <= '0;
        end else begin
            dl_prev_reg   <= ioctl_download;
            load_done_reg <= dl_prev_reg && !ioctl_download;
            if (ioctl_download && !dl_prev_reg && (ioctl_index == IDX_CART)) begin
                cart_size_reg <= '0;
            end else if ((state_reg == WR_HI) && ld_in_range_reg && (ld_region_reg == REG_CART)) begin
                if (word_end > cart_size_reg) begin
                    cart_size_reg <= (word_end > SIZE_W'(REGION_BYTES)) ? SIZE_W'(REGION_BYTES) : word_end;
                end
            end
        end
    end

`ifdef ASTRO_CART_MIRROR_EN
    // Remember whether this download targets the cart and refresh the mirror mask when it ends.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_cart_reg   <= 1'b0;
            cart_mask_reg <= '1;
        end else begin
            if (ioctl_download && !dl_prev_reg) begin
                dl_cart_reg <= (ioctl_index == IDX_CART);
            end else if (dl_prev_reg && !ioctl_download) begin
                dl_cart_reg <= 1'b0;
                if (dl_cart_reg) begin
                    cart_mask_reg <= cart_mask_new;
                end
            end
        end
    end
`endif

    // Read arbitration: BIOS first, then cart; only while the loader is quiet.
    always_comb begin
        read_ok  = !ioctl_download && (state_reg == IDLE);
        bios_req = read_ok && !bios_cs_n;
        cart_sel = read_ok && bios_cs_n && !cart_cs_n;
`ifdef ASTRO_CART_MIRROR_EN
        cart_blk = 1'b0;
        cart_req = cart_sel;
        cart_eff = cart_addr & cart_mask_reg;
`else
        cart_blk = cart_sel && ({1'b0, cart_addr} >= cart_size_reg);
        cart_req = cart_sel && !cart_blk;
        cart_eff = cart_addr;
`endif
    end

    // Memory port mux: loader writes win; otherwise the granted reader; otherwise hold.
    always_comb begin
        mem_addr_next = hold_addr_reg;
        mem_din_next  = '0;
        mem_we_next   = 1'b0;
        case (state_reg)
            WR_LO: begin
                mem_addr_next = {ld_region_reg, ld_addr_reg};
                mem_din_next  = ld_data_reg[7:0];
                mem_we_next   = ld_in_range_reg;
            end
            WR_HI: begin
                mem_addr_next = {ld_region_reg, ld_addr_reg[REGION_AW-1:1], 1'b1};
                mem_din_next  = ld_data_reg[15:8];
                mem_we_next   = ld_in_range_reg;
            end
            default: begin
                if (bios_req) begin
                    mem_addr_next = {REG_BIOS, bios_addr};
                end else if (cart_req) begin
                    mem_addr_next = {REG_CART, cart_eff};
                end
            end
        endcase
    end

    // Remember the last address presented so an idle port keeps it stable.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_addr_reg <= '0;
        end else begin
            hold_addr_reg <= mem_addr_next;
        end
    end

    // Read data capture: the cycle after the access, the owner latches mem_dout.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc_bios_reg  <= 1'b0;
            acc_cart_reg  <= 1'b0;
            blk_cart_reg  <= 1'b0;
            bios_data_reg <= FILL_BYTE;
            cart_data_reg <= FILL_BYTE;
        end else begin
            acc_bios_reg <= bios_req;
            acc_cart_reg <= cart_req;
            blk_cart_reg <= cart_blk;
            if (acc_bios_reg && !bios_cs_n) begin
                bios_data_reg <= mem_dout;
            end
            if (acc_cart_reg && !cart_cs_n) begin
                cart_data_reg <= mem_dout;
            end else if (blk_cart_reg && !cart_cs_n) begin
                cart_data_reg <= FILL_BYTE;
            end
        end
    end

    assign mem_addr   = mem_addr_next;
    assign mem_din    = mem_din_next;
    assign mem_we     = mem_we_next;
    assign ioctl_wait = ioctl_wait_reg;
    assign cart_size  = cart_size_reg;
    assign load_done  = load_done_reg;
    assign bios_data  = ioctl_download ? FILL_BYTE : bios_data_reg;
    assign cart_data  = (ioctl_download || (cart_size_reg == '0)) ? FILL_BYTE : cart_data_reg;

endmodule
